// File: rtl/pipe_mux_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_mux_n                                                    |
// | Purpose  : N-channel valid/ready mux with one registered output stage,   |
// |            directed-select or round-robin arbitration.                   |
// | Option   : PIPE_MUX_CNT_EN adds the xfer_cnt output handshake counter.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipe_mux_n #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32,
  localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SW-1:0]         sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SW-1:0]         out_src
`ifdef PIPE_MUX_CNT_EN
  ,
  output logic [31:0]           xfer_cnt
`endif
);

  localparam int NP = 1 << SW;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SW-1:0]    out_src_q,   out_src_d;
  logic [SW-1:0]    ptr_q,       ptr_d;

  logic [NP-1:0]    valid_pad;
  logic             can_load;
  logic             dir_hit;
  logic             rr_hit;
  logic [SW-1:0]    rr_idx;
  logic [SW:0]      scan_sum;
  logic [SW-1:0]    scan_idx;
  logic             grant_vld;
  logic [SW-1:0]    grant_idx;
  logic [WIDTH-1:0] grant_data;

  // Padding in_valid to 2**SW entries lets an out-of-range sel read a defined 0.
  always_comb begin
    valid_pad           = '0;
    valid_pad[N_CH-1:0] = in_valid;
    dir_hit = ({1'b0, sel} < (SW+1)'(N_CH)) && valid_pad[sel];

    rr_hit   = 1'b0;
    rr_idx   = '0;
    scan_sum = '0;
    scan_idx = '0;
    // Scan farthest-first so the channel closest to ptr is the final winner.
    for (int k = N_CH - 1; k >= 0; k--) begin
      scan_sum = {1'b0, ptr_q} + (SW+1)'(k);
      if (scan_sum >= (SW+1)'(N_CH)) begin
        scan_sum = scan_sum - (SW+1)'(N_CH);
      end
      scan_idx = scan_sum[SW-1:0];
      if (valid_pad[scan_idx]) begin
        rr_hit = 1'b1;
        rr_idx = scan_idx;
      end
    end

    can_load  = !out_valid_q || out_ready;
    grant_vld = !rst && can_load && (mode ? rr_hit : dir_hit);
    grant_idx = mode ? rr_idx : sel;
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = grant_vld;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (grant_vld) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_src_d   = grant_idx;
      if (mode) begin
        ptr_d = (grant_idx == SW'(N_CH - 1)) ? '0 : grant_idx + SW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef PIPE_MUX_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + {31'd0, out_valid_q & out_ready};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_mux_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipe_mux_n                                                 |
// | Purpose  : Scoreboard bench for pipe_mux_n (N_CH=4 main, N_CH=3 aux).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pipe_mux_n;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic           clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_src;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic           mode3;
  logic [1:0]     sel3;
  logic [W-1:0]   out_data3;
  logic           out_valid3;
  logic           out_ready3;
  logic [1:0]     out_src3;
`ifdef PIPE_MUX_CNT_EN
  logic [31:0]    xfer_cnt;
  logic [31:0]    xfer_cnt3;
`endif

  pipe_mux_n #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
`ifdef PIPE_MUX_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  pipe_mux_n #(.N_CH(3), .WIDTH(W)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .mode      (mode3),
    .sel       (sel3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_src   (out_src3)
`ifdef PIPE_MUX_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt3)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    int           src;
  } word_t;

  word_t       exp_q[$];
  int          src_log[$];
  int          ptr_m;
  logic [31:0] cnt_exp;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference grant: plain modular scan over the current inputs and model state.
  function automatic int model_grant();
    bit cl;
    cl = (exp_q.size() == 0) || out_ready;
    if (rst || !cl) return -1;
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr_m + k) % N;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    int         g;
    logic [N-1:0] exp_rdy;
    word_t      w;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
`ifdef PIPE_MUX_CNT_EN
    chk("xfer_cnt", 64'(xfer_cnt), 64'(cnt_exp));
`endif
    if (rst) begin
      exp_q.delete();
      ptr_m   = 0;
      cnt_exp = '0;
    end else if (g >= 0) begin
      w.d   = in_data[g*W +: W];
      w.src = g;
      exp_q.push_back(w);
      if (mode) ptr_m = (g + 1) % N;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: whenever the DUT will hand off a word at the coming edge, check it.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL monitor: unexpected word %0h src %0d", out_data, out_src);
        end else begin
          w = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(w.d));
          chk("out_src", 64'(out_src), 64'(w.src));
          src_log.push_back(int'(out_src));
          cnt_exp = cnt_exp + 32'd1;
        end
      end
    end
  end

  initial begin
    int exp_rr0[5];
    int exp_rr1[4];
    logic [W-1:0] d3;
    exp_rr0 = '{0, 1, 2, 3, 0};
    exp_rr1 = '{1, 3, 1, 3};
    ptr_m   = 0;
    cnt_exp = '0;
    rst = 1'b1; in_valid = 4'b1111; mode = 1'b0; sel = '0; out_ready = 1'b0;
    rand_data();
    in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;
    @(negedge clk);

    // Reset with all channels requesting.
    cycle();
    cycle();
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    rst = 1'b0; in_valid = 4'b0100; sel = 2'd2; out_ready = 1'b1;
    cycle();
    in_valid = '0;
    cycle();

    // Directed stream on ch1.
    sel = 2'd1; in_valid = 4'b1111;
    begin
      logic [W-1:0] vals[3];
      vals = '{32'h11111111, 32'h22222222, 32'h33333333};
      for (int i = 0; i < 3; i++) begin
        rand_data();
        in_data[W +: W] = vals[i];
        cycle();
      end
    end
    in_valid = '0;
    cycle();
    cycle();

    // Backpressure.
    sel = 2'd0; in_valid = 4'b0001; in_data[0 +: W] = 32'hDEADBEEF;
    cycle();
    in_data[0 +: W] = 32'hCAFEF00D; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold", 64'(out_data), 64'hDEADBEEF);
    end
    out_ready = 1'b1;
    cycle();
    in_valid = '0;
    cycle();
    chk("bp_load", 64'(out_data), 64'hCAFEF00D);

    // Round-robin fairness, all requesting, then 4'b1010.
    rst = 1'b1; cycle(); rst = 1'b0;
    mode = 1'b1; in_valid = 4'b1111; src_log.delete();
    for (int i = 0; i < 5; i++) begin rand_data(); cycle(); end
    in_valid = '0; cycle();
    chk("rr_cnt0", 64'(src_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < src_log.size(); i++) chk("rr_seq0", 64'(src_log[i]), 64'(exp_rr0[i]));
    rst = 1'b1; cycle(); rst = 1'b0;
    in_valid = 4'b1010; src_log.delete();
    for (int i = 0; i < 4; i++) begin rand_data(); cycle(); end
    in_valid = '0; cycle();
    chk("rr_cnt1", 64'(src_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < src_log.size(); i++) chk("rr_seq1", 64'(src_log[i]), 64'(exp_rr1[i]));

    // N_CH=3: out-of-range select, then round-robin resumes at retained ptr.
    mode = 1'b0;
    in_data3 = {$urandom, $urandom, $urandom};
    mode3 = 1'b1; in_valid3 = 3'b001;
    #1 chk("n3_rr_first", 64'(in_ready3), 64'b001);
    tick();
    in_valid3 = '0;
    #1 chk("n3_src0", 64'(out_src3), 64'd0);
    tick();
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1 chk("n3_oor_rdy", 64'(in_ready3), 64'd0);
      tick();
      chk("n3_oor_vld", 64'(out_valid3), 64'd0);
    end
    mode3 = 1'b1;
    d3 = in_data3[W +: W];
    #1 chk("n3_resume_rdy", 64'(in_ready3), 64'b010);
    tick();
    in_valid3 = '0;
    #1 chk("n3_resume_src", 64'(out_src3), 64'd1);
    chk("n3_resume_data", 64'(out_data3), 64'(d3));
    tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel       = SW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      rand_data();
      cycle();
    end
    rst = 1'b0; in_valid = '0; out_ready = 1'b1;
    cycle(); cycle(); cycle();
    chk("drained", 64'(exp_q.size()), 64'd0);

`ifdef PIPE_MUX_CNT_EN
    rst = 1'b1; cycle(); rst = 1'b0;
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin rand_data(); cycle(); end
    in_valid = '0; cycle(); cycle();
    chk("cnt_ten", 64'(xfer_cnt), 64'd10);
    force dut.cnt_q = 32'hFFFFFFFF;
    cnt_exp = 32'hFFFFFFFF;
    #1 release dut.cnt_q;
    in_valid = 4'b0001; cycle();
    in_valid = '0; cycle();
    chk("cnt_wrap", 64'(xfer_cnt), 64'd0);
    in_valid = 4'b0001; cycle();
    in_valid = '0; cycle();
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    chk("cnt_rst", 64'(xfer_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
